// File: rtl/dram_pkg.sv
// Shared widths, sequencer state encoding and open-row table entry for the DRAM command path.
package dram_pkg;
    localparam int NUM_BANKS = 8;
    localparam int NUM_ROWS  = 128;
    localparam int NUM_COLS  = 8;
    localparam int BANK_W    = $clog2(NUM_BANKS);
    localparam int ROW_W     = $clog2(NUM_ROWS);
    localparam int COL_W     = $clog2(NUM_COLS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACT1   = 3'd1,
        S_ACT2   = 3'd2,
        S_RD_COL = 3'd3,
        S_RD_CAP = 3'd4,
        S_WR     = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic             vld;
        logic [ROW_W-1:0] row;
    } open_row_t;
endpackage

// File: rtl/dram_open_row_table.sv
// Per-bank record of which row sits in the bank's row buffer.
// Lookup is combinational; set/invalidate take effect at the clock edge; rst_b clears every entry.
module dram_open_row_table
    import dram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_b,
    input  logic [BANK_W-1:0] lkp_bank_i,
    output logic              lkp_vld_o,
    output logic [ROW_W-1:0]  lkp_row_o,
    input  logic              set_i,
    input  logic [BANK_W-1:0] set_bank_i,
    input  logic [ROW_W-1:0]  set_row_i,
    input  logic              inv_i,
    input  logic [BANK_W-1:0] inv_bank_i
);
    open_row_t tbl_q [NUM_BANKS];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            tbl_q <= '{default: '0};
        end else begin
            if (inv_i) begin
                tbl_q[inv_bank_i].vld <= 1'b0;
            end
            if (set_i) begin
                tbl_q[set_bank_i] <= '{vld: 1'b1, row: set_row_i};
            end
        end
    end

    assign lkp_vld_o = tbl_q[lkp_bank_i].vld;
    assign lkp_row_o = tbl_q[lkp_bank_i].row;
endmodule

// File: rtl/dram_cmd_sequencer.sv
// Turns host read/write requests into banked-array activate/read/write cycles; resp 3 (hit) or 5 (miss) cycles after accept.
// req_ready only in IDLE. Open-page row tracking is enabled by DRAM_SEQ_OPEN_PAGE_EN, otherwise every read activates.
module dram_cmd_sequencer
    import dram_pkg::*;
#(
    parameter int NUM_OF_BANKS = NUM_BANKS,
    parameter int NUM_OF_ROWS  = NUM_ROWS,
    parameter int NUM_OF_COLS  = NUM_COLS,
    localparam int BW = $clog2(NUM_OF_BANKS),
    localparam int RW = $clog2(NUM_OF_ROWS),
    localparam int CW = $clog2(NUM_OF_COLS)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [BW-1:0] req_bank,
    input  logic [RW-1:0] req_row,
    input  logic [CW-1:0] req_col,
    input  logic          req_wdata,
    output logic          resp_valid,
    output logic          resp_rdata,
    output logic          bank_rw,
    output logic          buffer_rw,
    output logic [BW-1:0] bank_id,
    output logic [RW-1:0] rowid,
    output logic [CW-1:0] colid,
    inout  wire           data
);
    seq_state_t    state_q, state_d;
    logic [BW-1:0] bank_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic          wdata_q;
    logic          resp_valid_q;
    logic          resp_rdata_q;
    logic          accept;
    logic          hit;

    assign accept = req_valid && req_ready;

`ifdef DRAM_SEQ_OPEN_PAGE_EN
    logic [BW-1:0] lkp_bank;
    logic          lkp_vld;
    logic [RW-1:0] lkp_row;
    logic          tbl_set;
    logic          tbl_inv;

    // One lookup port: the request's bank while idle, the latched bank while writing.
    assign lkp_bank = (state_q == S_WR) ? bank_q : req_bank;
    assign hit      = lkp_vld && (lkp_row == req_row);
    assign tbl_set  = (state_q == S_ACT2);
    // A write to the open row leaves the buffered copy stale, so force the next read to reload.
    assign tbl_inv  = (state_q == S_WR) && lkp_vld && (lkp_row == row_q);

    dram_open_row_table u_tbl (
        .clk        (clk),
        .rst_b      (rst_b),
        .lkp_bank_i (lkp_bank),
        .lkp_vld_o  (lkp_vld),
        .lkp_row_o  (lkp_row),
        .set_i      (tbl_set),
        .set_bank_i (bank_q),
        .set_row_i  (row_q),
        .inv_i      (tbl_inv),
        .inv_bank_i (bank_q)
    );
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        buffer_rw = 1'b0;
        bank_rw   = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_we)   state_d = S_WR;
                    else if (hit) state_d = S_RD_COL;
                    else          state_d = S_ACT1;
                end
            end
            S_ACT1: begin
                buffer_rw = 1'b1;
                state_d   = S_ACT2;
            end
            S_ACT2: begin
                buffer_rw = 1'b1;
                state_d   = S_RD_COL;
            end
            S_RD_COL: state_d = S_RD_CAP;
            S_RD_CAP: state_d = S_IDLE;
            S_WR: begin
                bank_rw = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            bank_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            wdata_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 1'b0;
        end else begin
            if (accept) begin
                bank_q  <= req_bank;
                row_q   <= req_row;
                col_q   <= req_col;
                wdata_q <= req_wdata;
            end
            // The array's registered data_out is on the bus throughout RD_CAP.
            resp_valid_q <= (state_q == S_RD_CAP);
            if (state_q == S_RD_CAP) begin
                resp_rdata_q <= data;
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign bank_id    = bank_q;
    assign rowid      = row_q;
    assign colid      = col_q;
    assign data       = bank_rw ? wdata_q : 1'bz;
endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Drives dram_cmd_sequencer against a behavioural banked array; reads are scoreboarded by a response monitor.
`timescale 1ns/1ps
module tb_dram_cmd_sequencer;
    localparam int BW = 3;
    localparam int RW = 7;
    localparam int CW = 3;
`ifdef DRAM_SEQ_OPEN_PAGE_EN
    localparam bit OPEN_PAGE = 1'b1;
`else
    localparam bit OPEN_PAGE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [BW-1:0] req_bank = '0;
    logic [RW-1:0] req_row = '0;
    logic [CW-1:0] req_col = '0;
    logic          req_wdata = 1'b0;
    wire           req_ready;
    wire           resp_valid;
    wire           resp_rdata;
    wire           bank_rw;
    wire           buffer_rw;
    wire [BW-1:0]  bank_id;
    wire [RW-1:0]  rowid;
    wire [CW-1:0]  colid;
    wire           data;

    always #5 clk = ~clk;

    dram_cmd_sequencer dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_bank   (req_bank),
        .req_row    (req_row),
        .req_col    (req_col),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .bank_rw    (bank_rw),
        .buffer_rw  (buffer_rw),
        .bank_id    (bank_id),
        .rowid      (rowid),
        .colid      (colid),
        .data       (data)
    );

    // Behavioural array: two-cycle row copy into the buffer, registered column read.
    logic       arr_clr = 1'b1;
    logic [7:0] mem [8][128];
    logic [7:0] rowbuf [8];
    logic [7:0] stage_q;
    logic       stage_vld_q;
    logic       dout_q;

    always @(posedge clk) begin
        if (arr_clr) begin
            for (int b = 0; b < 8; b++) begin
                for (int r = 0; r < 128; r++) mem[b][r] <= 8'h00;
                rowbuf[b] <= 8'h00;
            end
            stage_q     <= 8'h00;
            stage_vld_q <= 1'b0;
            dout_q      <= 1'b0;
        end else begin
            stage_vld_q <= buffer_rw;
            if (buffer_rw) begin
                stage_q <= mem[bank_id][rowid];
                if (stage_vld_q) rowbuf[bank_id] <= stage_q;
            end else if (bank_rw) begin
                mem[bank_id][rowid][colid] <= data;
            end else begin
                dout_q <= rowbuf[bank_id][colid];
            end
        end
    end

    assign data = bank_rw ? 1'bz : dout_q;

    typedef struct {
        int   id;
        logic exp_rdata;
        int   acc_cyc;
        int   buf0;
        int   exp_lat;
        int   exp_buf;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   buf_cnt = 0;
    int   last_resp_cyc = -100;
    int   n_tests = 0;
    int   n_fail = 0;
    logic prev_resp = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_b) begin
            if (buffer_rw) buf_cnt++;
            if (resp_valid) begin
                check("resp_single_cycle", prev_resp, 0);
                check("sb_depth_at_resp", sb.size(), 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("rd%0d_rdata", e.id), resp_rdata, e.exp_rdata);
                    check($sformatf("rd%0d_latency", e.id), cyc - e.acc_cyc + 1, e.exp_lat);
                    check($sformatf("rd%0d_buffer_rw_cycles", e.id), buf_cnt - e.buf0, e.exp_buf);
                end
                last_resp_cyc = cyc;
            end else if (sb.size() > 0) begin
                check("ready_low_while_busy", req_ready, 0);
            end
            prev_resp = resp_valid;
        end else begin
            prev_resp = 1'b0;
        end
    end

    // Leaves req_valid high on return; reads are handed to the monitor, writes are checked inline.
    task automatic issue(input int id, input bit we, input int b, input int r, input int c,
                         input bit wd, input bit open_hit, input bit exp_rd);
        int   waited;
        bit   hit;
        exp_t e;
        waited    = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_bank  = BW'(b);
        req_row   = RW'(r);
        req_col   = CW'(c);
        req_wdata = wd;
        while (!req_ready && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check($sformatf("req%0d_accept_timeout", id), req_ready, 1);
            return;
        end
        @(posedge clk);
        #1;
        if (!we) begin
            hit         = OPEN_PAGE && open_hit;
            e.id        = id;
            e.exp_rdata = exp_rd;
            e.acc_cyc   = cyc;
            e.buf0      = buf_cnt;
            e.exp_lat   = hit ? 3 : 5;
            e.exp_buf   = hit ? 0 : 2;
            sb.push_back(e);
        end else begin
            check($sformatf("wr%0d_bank_rw", id), bank_rw, 1);
            check($sformatf("wr%0d_ready_busy", id), req_ready, 0);
            check($sformatf("wr%0d_data_bus", id), data, wd);
            @(posedge clk);
            #1;
            check($sformatf("wr%0d_ready_back", id), req_ready, 1);
            check($sformatf("wr%0d_bank_rw_off", id), bank_rw, 0);
        end
    endtask

    task automatic drain();
        req_valid = 1'b0;
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check("drain_empty", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_rdata"}, resp_rdata, 0);
        check({tag, "_bank_rw"}, bank_rw, 0);
        check({tag, "_buffer_rw"}, buffer_rw, 0);
        check({tag, "_bank_id"}, bank_id, 0);
        check({tag, "_rowid"}, rowid, 0);
        check({tag, "_colid"}, colid, 0);
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: time limit reached with %0d responses outstanding", sb.size());
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        arr_clr = 1'b0;
        rst_b   = 1'b1;
        @(negedge clk);

        // Write then miss read; second write to the open row makes the next read miss again.
        issue(1, 1'b1, 2, 5, 3, 1'b1, 1'b0, 1'b0);
        issue(2, 1'b0, 2, 5, 3, 1'b0, 1'b0, 1'b1);
        issue(3, 1'b1, 2, 5, 6, 1'b1, 1'b0, 1'b0);
        issue(4, 1'b0, 2, 5, 3, 1'b0, 1'b0, 1'b1);
        issue(5, 1'b0, 2, 5, 6, 1'b0, 1'b1, 1'b1);
        // Repeat read hits; a write to another row of the bank keeps the open row.
        issue(6, 1'b0, 4, 9, 0, 1'b0, 1'b0, 1'b0);
        issue(7, 1'b0, 4, 9, 0, 1'b0, 1'b1, 1'b0);
        issue(8, 1'b1, 4, 10, 1, 1'b1, 1'b0, 1'b0);
        issue(9, 1'b0, 4, 9, 0, 1'b0, 1'b1, 1'b0);
        issue(10, 1'b0, 4, 10, 1, 1'b0, 1'b0, 1'b1);
        drain();

        // Back-to-back stream with req_valid held high throughout.
        issue(11, 1'b0, 4, 10, 1, 1'b0, 1'b1, 1'b1);
        issue(12, 1'b0, 7, 127, 7, 1'b0, 1'b0, 1'b0);
        check("b2b_accept_12", cyc, last_resp_cyc + 1);
        issue(13, 1'b0, 7, 127, 7, 1'b0, 1'b1, 1'b0);
        check("b2b_accept_13", cyc, last_resp_cyc + 1);
        issue(14, 1'b0, 4, 10, 1, 1'b0, 1'b1, 1'b1);
        check("b2b_accept_14", cyc, last_resp_cyc + 1);
        drain();

        // Abort a miss read in ACT2.
        issue(15, 1'b0, 1, 3, 2, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("abort_in_act2_buffer_rw", buffer_rw, 1);
        sb.delete();
        req_valid = 1'b0;
        rst_b     = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midop_reset_no_resp", resp_valid, 0);
        end
        rst_b = 1'b1;
        @(negedge clk);

        // Table cleared by reset: previously open row misses; corner bank/row/col.
        issue(16, 1'b0, 4, 10, 1, 1'b0, 1'b0, 1'b1);
        issue(17, 1'b1, 7, 127, 7, 1'b1, 1'b0, 1'b0);
        issue(18, 1'b0, 7, 127, 7, 1'b0, 1'b0, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
